// File: rtl/tvram_dma_pkg.sv
// Shared types and constants for the Batrider text/palette DMA scheduler.
package tvram_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOCK,
    ISSUE,
    WAIT,
    CAPTURE,
    HOLD,
    RELEASE
  } state_t;

  typedef enum logic {
    CMD_TD,
    CMD_PT
  } cmd_t;

  // Word-address boundaries of the TVRAM banks, decoded downstream of WR_ADDR.
  localparam logic [13:0] BANK_TEXT_END   = 14'h1000;
  localparam logic [13:0] BANK_PAL_END    = 14'h1800;
  localparam logic [13:0] BANK_SEL_END    = 14'h1900;
  localparam logic [13:0] BANK_SCROLL_END = 14'h1A00;

  // True while a word read/write is in flight on the bus.
  function automatic logic is_xfer(input state_t s);
    return (s == ISSUE) || (s == WAIT) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/tvram_dma_sched_if.sv
// Command, bus-handshake, main-RAM read and TVRAM write signals of the DMA scheduler.
interface tvram_dma_sched_if;
  logic        TEXTDATA_REQ;
  logic        PALTEXT_REQ;
  logic        BUSACK;
  logic        BUSREQ;
  logic        BUSY;
  logic        DMA_RAM_CS;
  logic [13:0] DMA_RAM_ADDR;
  logic [15:0] DMA_RAM_DATA;
  logic        WR_EN;
  logic [13:0] WR_ADDR;
  logic [15:0] WR_DATA;
  logic        TEXTROM_LOCK;
  logic        DONE;
  logic        ACK_ERR;

  // Environment side: CPU command decode, 68K bus owner and main RAM.
  modport master (
    output TEXTDATA_REQ, PALTEXT_REQ, BUSACK, DMA_RAM_DATA,
    input  BUSREQ, BUSY, DMA_RAM_CS, DMA_RAM_ADDR, WR_EN, WR_ADDR, WR_DATA,
           TEXTROM_LOCK, DONE, ACK_ERR
  );

  // Scheduler side.
  modport slave (
    input  TEXTDATA_REQ, PALTEXT_REQ, BUSACK, DMA_RAM_DATA,
    output BUSREQ, BUSY, DMA_RAM_CS, DMA_RAM_ADDR, WR_EN, WR_ADDR, WR_DATA,
           TEXTROM_LOCK, DONE, ACK_ERR
  );
endinterface

// File: rtl/tvram_dma_cmdq.sv
// Pending-command flags with coalescing and text-over-palette priority select.
module tvram_dma_cmdq
  import tvram_dma_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic td_req_i,
  input  logic pt_req_i,
  input  logic lock_i,
  input  logic take_i,
  output logic valid_o,
  output cmd_t sel_o,
  output logic pend_any_d_o
);

  logic pend_td_q, pend_td_d;
  logic pend_pt_q, pend_pt_d;
  logic td_avail_s, pt_avail_s;

  // A same-cycle pulse is visible immediately so IDLE can leave without an extra cycle.
  always_comb begin
    td_avail_s = pend_td_q | (td_req_i & ~lock_i);
    pt_avail_s = pend_pt_q | pt_req_i;
    valid_o    = td_avail_s | pt_avail_s;
    if (td_avail_s) begin
      sel_o = CMD_TD;
    end else begin
      sel_o = CMD_PT;
    end
  end

  // A flag holds at most one queued run; the chosen one is consumed when IDLE is left.
  always_comb begin
    pend_td_d    = td_avail_s & ~(take_i & (sel_o == CMD_TD));
    pend_pt_d    = pt_avail_s & ~(take_i & (sel_o == CMD_PT));
    pend_any_d_o = pend_td_d | pend_pt_d;
  end

  // Pending flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_td_q <= 1'b0;
      pend_pt_q <= 1'b0;
    end else begin
      pend_td_q <= pend_td_d;
      pend_pt_q <= pend_pt_d;
    end
  end

endmodule

// File: rtl/tvram_dma_sched.sv
// Batrider text/palette DMA sequencer: bus handshake, main-RAM reads, TVRAM writes.
module tvram_dma_sched
  import tvram_dma_pkg::*;
#(
  parameter logic [13:0] PALTEXT_LEN = BANK_SCROLL_END,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic               CLK96,
  input  logic               RESET96,
  tvram_dma_sched_if.slave   bus
);

  localparam int          TO_W      = $clog2(ACK_TIMEOUT);
  localparam logic [13:0] LAST_WORD = PALTEXT_LEN - 14'd1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  LAT_LAST  = 3'(RD_LAT - 1);

  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [13:0]     wcnt_q, wcnt_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic [2:0]      lcnt_q, lcnt_d;
  logic            lost_q, lost_d;
  logic            take_s, done_s, err_s;
  logic            q_valid_s, q_pend_d_s;
  cmd_t            q_sel_s;

  logic            busreq_q, busy_q, cs_q, wr_en_q, lock_q, done_q, err_q;
  logic [13:0]     addr_q, wr_addr_q;
  logic [15:0]     wr_data_q;

  tvram_dma_cmdq u_cmdq (
    .clk_i        (CLK96),
    .rst_i        (RESET96),
    .td_req_i     (bus.TEXTDATA_REQ),
    .pt_req_i     (bus.PALTEXT_REQ),
    .lock_i       (lock_q),
    .take_i       (take_s),
    .valid_o      (q_valid_s),
    .sel_o        (q_sel_s),
    .pend_any_d_o (q_pend_d_s)
  );

  // Next-state, counters and completion/error events.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    lcnt_d  = lcnt_q;
    take_s  = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    // Remember a grant loss during a word so the word finishes before parking in HOLD.
    if (is_xfer(state_q) && !bus.BUSACK) begin
      lost_d = 1'b1;
    end else begin
      lost_d = lost_q;
    end
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        lost_d = 1'b0;
        if (q_valid_s) begin
          take_s  = 1'b1;
          cmd_d   = q_sel_s;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.BUSACK) begin
          tcnt_d = '0;
          if (cmd_q == CMD_TD) begin
            state_d = LOCK;
          end else begin
            state_d = ISSUE;
          end
        end else if (tcnt_q == TO_LAST) begin
          tcnt_d  = '0;
          err_s   = 1'b1;
          state_d = RELEASE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      LOCK: begin
        done_s  = 1'b1;
        state_d = RELEASE;
      end
      ISSUE: begin
        lcnt_d  = 3'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (lcnt_q == LAT_LAST) begin
          lcnt_d  = 3'd0;
          state_d = CAPTURE;
        end else begin
          lcnt_d = lcnt_q + 3'd1;
        end
      end
      CAPTURE: begin
        wcnt_d = wcnt_q + 14'd1;
        if (wcnt_q == LAST_WORD) begin
          done_s  = 1'b1;
          state_d = RELEASE;
        end else if (lost_d) begin
          state_d = HOLD;
        end else begin
          state_d = ISSUE;
        end
      end
      HOLD: begin
        if (bus.BUSACK) begin
          lost_d  = 1'b0;
          state_d = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      RELEASE: begin
        wcnt_d  = 14'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and outputs; all outputs are registered from the next state.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_TD;
      wcnt_q    <= 14'd0;
      tcnt_q    <= '0;
      lcnt_q    <= 3'd0;
      lost_q    <= 1'b0;
      busreq_q  <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b0;
      addr_q    <= 14'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 14'd0;
      wr_data_q <= 16'd0;
      lock_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      lcnt_q   <= lcnt_d;
      lost_q   <= lost_d;
      busreq_q <= (state_d != IDLE) && (state_d != RELEASE);
      busy_q   <= q_pend_d_s | (state_d != IDLE);
      cs_q     <= (state_d == ISSUE) || (state_d == WAIT);
      wr_en_q  <= (state_d == CAPTURE);
      lock_q   <= lock_q | (state_q == LOCK);
      done_q   <= done_s;
      err_q    <= err_s;
      if (state_d == ISSUE) begin
        addr_q <= wcnt_d;
      end
      if (state_d == CAPTURE) begin
        wr_addr_q <= wcnt_q;
        wr_data_q <= bus.DMA_RAM_DATA;
      end
    end
  end

  assign bus.BUSREQ       = busreq_q;
  assign bus.BUSY         = busy_q;
  assign bus.DMA_RAM_CS   = cs_q;
  assign bus.DMA_RAM_ADDR = addr_q;
  assign bus.WR_EN        = wr_en_q;
  assign bus.WR_ADDR      = wr_addr_q;
  assign bus.WR_DATA      = wr_data_q;
  assign bus.TEXTROM_LOCK = lock_q;
  assign bus.DONE         = done_q;
  assign bus.ACK_ERR      = err_q;

endmodule

// File: tb/tb_tvram_dma_sched.sv
// Scoreboard bench for tvram_dma_sched: expected write/done/error events are queued by
// the stimulus and consumed by an independent monitor on the falling clock edge.
module tb_tvram_dma_sched;

  localparam int N      = 'h1A00;
  localparam int ACK_TO = 1024;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] addr;
    logic [15:0] data;
  } ev_t;

  logic CLK96   = 1'b0;
  logic RESET96 = 1'b1;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  ev_t  exp_q[$];
  ev_t  mon_got, mon_exp;
  logic [15:0] rd_p1, rd_p2;

  tvram_dma_sched_if bus();

  tvram_dma_sched dut (
    .CLK96   (CLK96),
    .RESET96 (RESET96),
    .bus     (bus)
  );

  always #5 CLK96 = ~CLK96;

  always @(posedge CLK96) cyc <= cyc + 1;

  // Main-RAM model content.
  function automatic logic [15:0] mem_word(input logic [13:0] a);
    return {a[7:0], 2'b11, a[13:8]} ^ 16'hA55A;
  endfunction

  // Main RAM with a two-cycle read latency.
  always @(posedge CLK96) begin
    rd_p1 <= mem_word(bus.DMA_RAM_ADDR);
    rd_p2 <= rd_p1;
  end
  assign bus.DMA_RAM_DATA = rd_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] ctrl_bits();
    return {bus.BUSREQ, bus.BUSY, bus.DMA_RAM_CS, bus.WR_EN, bus.TEXTROM_LOCK, bus.DONE, bus.ACK_ERR};
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0: return bus.DONE;
      1: return bus.ACK_ERR;
      3: return bus.WR_EN && (bus.WR_ADDR == 14'h0100);
      4: return bus.DMA_RAM_CS && (bus.DMA_RAM_ADDR == 14'h0800);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK96);
      if (sig(w)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic push_writes(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_q.push_back({EV_WR, 14'(i), mem_word(14'(i))});
    end
  endtask

  task automatic push_ev(input logic [1:0] k);
    exp_q.push_back({k, 14'd0, 16'd0});
  endtask

  task automatic pulse(input logic td, input logic pt);
    @(posedge CLK96); #1;
    bus.TEXTDATA_REQ = td;
    bus.PALTEXT_REQ  = pt;
    @(posedge CLK96); #1;
    bus.TEXTDATA_REQ = 1'b0;
    bus.PALTEXT_REQ  = 1'b0;
  endtask

  // Monitor: every WR_EN / DONE / ACK_ERR is matched against the next queued event.
  always @(negedge CLK96) begin
    if (!RESET96 && (bus.WR_EN || bus.DONE || bus.ACK_ERR)) begin
      mon_got.kind = bus.WR_EN ? EV_WR : (bus.DONE ? EV_DONE : EV_ERR);
      mon_got.addr = bus.WR_EN ? bus.WR_ADDR : 14'd0;
      mon_got.data = bus.WR_EN ? bus.WR_DATA : 16'd0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got event %0h required none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_event", mon_got, mon_exp);
        if ((bus.WR_EN && bus.DONE) || (bus.WR_EN && bus.ACK_ERR) || (bus.DONE && bus.ACK_ERR)) begin
          check("sb_single_event", 32'(ctrl_bits()), 32'(ctrl_bits() & 7'b1110111));
        end
      end
    end
  end

  initial begin
    int g, at, r, cnt_cs, cnt_lo;
    bus.TEXTDATA_REQ = 1'b0;
    bus.PALTEXT_REQ  = 1'b0;
    bus.BUSACK       = 1'b0;
    repeat (3) @(posedge CLK96);
    #1;
    check("rst_ctrl", 32'(ctrl_bits()), 32'd0);
    check("rst_addr", {4'd0, bus.DMA_RAM_ADDR, bus.WR_ADDR}, 32'd0);
    check("rst_wdata", 32'(bus.WR_DATA), 32'd0);
    RESET96 = 1'b0;
    repeat (2) @(posedge CLK96);

    // Palette/text copy with grant two cycles after BUSREQ.
    push_writes(0, N - 1);
    push_ev(EV_DONE);
    @(posedge CLK96); #1;
    bus.PALTEXT_REQ = 1'b1;
    check("t1_busreq_before", 32'(bus.BUSREQ), 32'd0);
    @(posedge CLK96); #1;
    bus.PALTEXT_REQ = 1'b0;
    check("t1_busreq_rise", 32'(bus.BUSREQ), 32'd1);
    check("t1_busy", 32'(bus.BUSY), 32'd1);
    @(posedge CLK96); #1;
    bus.BUSACK = 1'b1;
    g = cyc + 1;
    wait_for(0, N * 4 + 100, "t1_done", at);
    check("t1_done_time", 32'(at), 32'(g + N * 4));
    check("t1_busreq_fall", 32'(bus.BUSREQ), 32'd0);
    bus.BUSACK = 1'b0;
    repeat (2) @(posedge CLK96); #1;
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t1_busy_idle", 32'(bus.BUSY), 32'd0);

    // Text-ROM unpack: lock and done, no writes.
    push_ev(EV_DONE);
    pulse(1'b1, 1'b0);
    check("t2_busreq_rise", 32'(bus.BUSREQ), 32'd1);
    @(posedge CLK96); #1;
    bus.BUSACK = 1'b1;
    g = cyc + 1;
    wait_for(0, 20, "t2_done", at);
    check("t2_done_time", 32'(at), 32'(g + 1));
    check("t2_lock", 32'(bus.TEXTROM_LOCK), 32'd1);
    bus.BUSACK = 1'b0;
    repeat (2) @(posedge CLK96); #1;
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    bus.TEXTDATA_REQ = 1'b1;
    @(posedge CLK96); #1;
    bus.TEXTDATA_REQ = 1'b0;
    cnt_lo = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK96);
      if (bus.BUSREQ || bus.BUSY) cnt_lo++;
    end
    check("t2_td_ignored", 32'(cnt_lo), 32'd0);

    // BUSACK never granted: timeout.
    push_ev(EV_ERR);
    pulse(1'b0, 1'b1);
    r = cyc;
    check("t4_busreq_rise", 32'(bus.BUSREQ), 32'd1);
    wait_for(1, ACK_TO + 50, "t4_ackerr", at);
    check("t4_err_time", 32'(at), 32'(r + ACK_TO));
    check("t4_busreq_low", 32'(bus.BUSREQ), 32'd0);
    repeat (3) @(posedge CLK96); #1;
    check("t4_busy", 32'(bus.BUSY), 32'd0);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a copy, at word 0x0100.
    push_writes(0, 'h100);
    pulse(1'b0, 1'b1);
    @(posedge CLK96); #1;
    bus.BUSACK = 1'b1;
    wait_for(3, 'h101 * 4 + 50, "t5_word100", at);
    #2;
    RESET96 = 1'b1;
    #1;
    check("t5_rst_ctrl", 32'(ctrl_bits()), 32'd0);
    check("t5_rst_addr", {4'd0, bus.DMA_RAM_ADDR, bus.WR_ADDR}, 32'd0);
    bus.BUSACK = 1'b0;
    @(posedge CLK96); #1;
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge CLK96); #1;
    RESET96 = 1'b0;
    repeat (2) @(posedge CLK96);

    // Both commands in one cycle, grant dropped at word 0x0800 for 50 cycles.
    push_ev(EV_DONE);
    push_writes(0, N - 1);
    push_ev(EV_DONE);
    pulse(1'b1, 1'b1);
    check("t3_busreq_rise", 32'(bus.BUSREQ), 32'd1);
    @(posedge CLK96); #1;
    bus.BUSACK = 1'b1;
    g = cyc + 1;
    wait_for(0, 20, "t3_td_done", at);
    check("t3_td_done_time", 32'(at), 32'(g + 1));
    check("t3_lock", 32'(bus.TEXTROM_LOCK), 32'd1);
    check("t3_busreq_gap", 32'(bus.BUSREQ), 32'd0);
    check("t3_busy_pt_pending", 32'(bus.BUSY), 32'd1);
    wait_for(4, 'h801 * 4 + 100, "t3_word800", at);
    #2;
    bus.BUSACK = 1'b0;
    cnt_cs = 0;
    cnt_lo = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK96);
      if (bus.DMA_RAM_CS) cnt_cs++;
      if (!bus.BUSREQ) cnt_lo++;
    end
    check("t3_gap_cs", 32'(cnt_cs), 32'd2);
    check("t3_gap_busreq", 32'(cnt_lo), 32'd0);
    bus.BUSACK = 1'b1;
    wait_for(0, (N - 'h800) * 4 + 200, "t3_pt_done", at);
    check("t3_busreq_fall", 32'(bus.BUSREQ), 32'd0);
    bus.BUSACK = 1'b0;
    repeat (3) @(posedge CLK96); #1;
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t3_busy_idle", 32'(bus.BUSY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
